// File: rtl/fix_lut_step_sequencer_if.sv
// Handshake bundle between a pass requester and the LUT step sequencer.
interface fix_lut_step_sequencer_if #(
    parameter int STEP_W = 2
);
    logic              sample;
    logic [STEP_W-1:0] step_sel;
    logic              slice_zero;
    logic              acc_clr;
    logic              acc_en;
    logic              res_load;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output sample,
        input  step_sel, slice_zero, acc_clr, acc_en, res_load, busy, done, overrun
    );

    modport slave (
        input  sample,
        output step_sel, slice_zero, acc_clr, acc_en, res_load, busy, done, overrun
    );
endinterface

// File: rtl/fix_lut_step_sequencer.sv
// Sequences one LUT accumulation pass per sample rise: slice stepping, accumulator
// clear/enable aligned to the adder-tree latency, and the result strobe.
module fix_lut_step_sequencer #(
    parameter int STEPS_NUM  = 4,
    parameter int PIPE_DEPTH = 2,
    parameter int STEP_W     = (STEPS_NUM > 1) ? $clog2(STEPS_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rstPulse,
    fix_lut_step_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, LOAD} state_t;

    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS_NUM - 1);

    state_t              state;
    logic                sample_q;
    logic [STEP_W-1:0]   step_q;
    logic [PIPE_DEPTH:0] vld_pipe;
    logic                slice_zero_q, acc_clr_q, res_load_q, busy_q, done_q, overrun_q;

    logic rise, start, last_step, feed_nxt, tail_busy;

    assign rise      = bus.sample & ~sample_q;
    assign start     = rise & ((state == IDLE) | (state == LOAD));
    assign last_step = (step_q == LAST);
    assign feed_nxt  = start | ((state == FEED) & ~last_step);

    // Tokens still queued behind the exit stage keep DRAIN alive.
    always_comb begin
        tail_busy = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) tail_busy |= vld_pipe[i];
    end

    always_ff @(posedge clk or posedge rstPulse) begin
        if (rstPulse) begin
            state        <= IDLE;
            sample_q     <= 1'b1;
            step_q       <= '0;
            vld_pipe     <= '0;
            slice_zero_q <= 1'b1;
            acc_clr_q    <= 1'b0;
            res_load_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sample_q    <= bus.sample;
            acc_clr_q   <= 1'b0;
            res_load_q  <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= rise & ((state == FEED) | (state == DRAIN));
            vld_pipe[0] <= feed_nxt;
            for (int i = 1; i <= PIPE_DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];

            case (state)
                IDLE, LOAD: begin
                    // LOAD's closing edge may accept a new rise for back-to-back passes.
                    if (start) begin
                        state        <= FEED;
                        step_q       <= '0;
                        slice_zero_q <= 1'b0;
                        acc_clr_q    <= 1'b1;
                        busy_q       <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                FEED: begin
                    if (last_step) begin
                        step_q       <= '0;
                        slice_zero_q <= 1'b1;
                        if (PIPE_DEPTH == 0) begin
                            state      <= LOAD;
                            res_load_q <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!tail_busy) begin
                        state      <= LOAD;
                        res_load_q <= 1'b1;
                        done_q     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.step_sel   = step_q;
    assign bus.slice_zero = slice_zero_q;
    assign bus.acc_clr    = acc_clr_q;
    assign bus.acc_en     = vld_pipe[PIPE_DEPTH];
    assign bus.res_load   = res_load_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;
endmodule
